mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage_dmem_handshake.sv | 68 ++++++
 rtl/mem_stage.sv | 83 ++++++++
 tb/tb_mem_stage.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_pkg: shared EX/MEM and MEM/WB layouts, MemtoReg codes, FSM states.
// Pipeline register widths are fixed by the stage boundary definitions.
package mem_pkg;

  localparam int EXMEM_W = 106;
  localparam int MEMWB_W = 38;
  localparam int XLEN    = 32;
  localparam int RIDX_W  = 5;

  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_LOAD = 2'b01,
    M2R_PC4  = 2'b10,
    M2R_RSVD = 2'b11
  } memtoreg_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

  // MSB first: [105:74] pc4 .. [31:0] store data
  typedef struct packed {
    logic [XLEN-1:0]   pc4;
    logic [1:0]        memtoReg;
    logic              regWrite;
    logic              memWrite;
    logic              memRead;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   storeData;
  } ex_mem_t;

  typedef struct packed {
    logic              regWrite;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } mem_wb_t;

  function automatic logic isAligned(input logic [XLEN-1:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data memory req/ready bus.
// master = pipeline stage, slave = memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// dmem_handshake: IDLE/WAIT tracking, stall/req and optional timeout.
// Optional feature macro: MEM_TIMEOUT_EN (wait counter + sticky fault).
module dmem_handshake
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic aligned,
  input  logic ready,
  output logic req,
  output logic stall,
  output logic timeoutHit,
  output logic fault
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT out of range 1..65535");
  end

  hs_state_e state;

  assign req   = access & aligned;
  assign stall = req & ~ready & ~timeoutHit;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] waitCnt;

  assign timeoutHit = req & ~ready & (state == WAIT)
                    & (waitCnt == 16'(TIMEOUT));

  // State, wait-cycle count and sticky fault; count clears when not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      fault   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (stall) state <= WAIT;
        WAIT: if (!stall) state <= IDLE;
        default: state <= IDLE;
      endcase
      waitCnt <= stall ? waitCnt + 16'd1 : '0;
      if (timeoutHit) fault <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign fault      = 1'b0;

  // State register: WAIT persists until the memory answers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (stall) state <= WAIT;
        WAIT: if (!stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store over req/ready bus, stall, forwarding, MEM/WB reg.
// Optional feature macro: MEM_TIMEOUT_EN (abort slow accesses).
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [EXMEM_W-1:0] EX_MEM,
  mem_stage_if.master        dmem,
  output logic               mem_stall,
  output logic               mem_misalign,
  output logic               mem_fault,
  output logic               MEM_RegWrite,
  output logic [RIDX_W-1:0]  MEM_WriteRegister,
  output logic [XLEN-1:0]    MEM_RegWriteData,
  output logic [MEMWB_W-1:0] MEM_WB
);

  ex_mem_t         ex;
  logic            access;
  logic            aligned;
  logic            timeoutHit;
  logic [XLEN-1:0] wbData;
  mem_wb_t         wbNext;

  assign ex      = ex_mem_t'(EX_MEM);
  assign access  = ex.memRead | ex.memWrite;
  assign aligned = isAligned(ex.alu);

  dmem_handshake #(
    .TIMEOUT(TIMEOUT)
  ) u_hs (
    .clk       (clk),
    .rst       (rst),
    .access    (access),
    .aligned   (aligned),
    .ready     (dmem.dmem_ready),
    .req       (dmem.dmem_req),
    .stall     (mem_stall),
    .timeoutHit(timeoutHit),
    .fault     (mem_fault)
  );

  assign dmem.dmem_we    = ex.memWrite;
  assign dmem.dmem_addr  = ex.alu;
  assign dmem.dmem_wdata = ex.storeData;

  assign mem_misalign = access & ~aligned;

  assign MEM_RegWrite      = ex.regWrite;
  assign MEM_WriteRegister = ex.rd;
  assign MEM_RegWriteData  =
    (ex.memtoReg == M2R_PC4) ? ex.pc4 : ex.alu;

  // Writeback select: load data, link address, or ALU result
  always_comb begin
    wbData = ex.alu;
    unique case (1'b1)
      (ex.memtoReg == M2R_LOAD): wbData = dmem.dmem_rdata;
      (ex.memtoReg == M2R_PC4):  wbData = ex.pc4;
      default:                   wbData = ex.alu;
    endcase
  end

  // Candidate MEM/WB value; killed on stall, abort or misalign
  always_comb begin
    wbNext = '0;
    if (!(mem_stall | timeoutHit | mem_misalign)) begin
      wbNext.regWrite = ex.regWrite;
      wbNext.rd       = ex.rd;
      wbNext.data     = wbData;
    end
  end

  // MEM/WB pipeline register: bubbles while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) MEM_WB <= '0;
    else     MEM_WB <= wbNext;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Exercises the timeout path when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [105:0] exMem;
  logic         memStall;
  logic         memMisalign;
  logic         memFault;
  logic         fwdRw;
  logic [4:0]   fwdReg;
  logic [31:0]  fwdData;
  logic [37:0]  memWb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [37:0] wb;
    logic [37:0] mask;
  } exp_t;

  exp_t expQ[$];

  mem_stage_if bus ();

  mem_stage #(
    .TIMEOUT(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .EX_MEM           (exMem),
    .dmem             (bus),
    .mem_stall        (memStall),
    .mem_misalign     (memMisalign),
    .mem_fault        (memFault),
    .MEM_RegWrite     (fwdRw),
    .MEM_WriteRegister(fwdReg),
    .MEM_RegWriteData (fwdData),
    .MEM_WB           (memWb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [105:0] mk(
    input logic [31:0] pc4, input logic [1:0] m2r,
    input logic rw, input logic mw, input logic mr,
    input logic [4:0] rd, input logic [31:0] alu,
    input logic [31:0] sd);
    return {pc4, m2r, rw, mw, mr, rd, alu, sd};
  endfunction

  // One pipeline cycle: drive, check comb outputs, push/pop MEM_WB
  task automatic cyc(input logic [105:0] em, input logic rdy,
                     input logic [31:0] rdat, input logic expStall);
    logic        acc, al, rw;
    logic [1:0]  m2r;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, d;
    exp_t        e;
    exMem = em;
    bus.dmem_ready = rdy;
    bus.dmem_rdata = rdat;
    #2;
    alu = em[63:32];
    rd  = em[68:64];
    rw  = em[71];
    m2r = em[73:72];
    pc4 = em[105:74];
    acc = em[69] | em[70];
    al  = (alu[1:0] == 2'b00);
    chk("stall", 64'(memStall), 64'(expStall));
    chk("req", 64'(bus.dmem_req), 64'(acc & al));
    chk("misalign", 64'(memMisalign), 64'(acc & ~al));
    if (acc & al) begin
      chk("we", 64'(bus.dmem_we), 64'(em[70]));
      chk("addr", 64'(bus.dmem_addr), 64'(alu));
      if (em[70]) chk("wdata", 64'(bus.dmem_wdata), 64'(em[31:0]));
    end
    chk("fwdRw", 64'(fwdRw), 64'(rw));
    chk("fwdReg", 64'(fwdReg), 64'(rd));
    chk("fwdData", 64'(fwdData), 64'((m2r == 2'b10) ? pc4 : alu));
    d = (m2r == 2'b01) ? rdat : (m2r == 2'b10) ? pc4 : alu;
    e.mask = '1;
    if (expStall || (acc & al & ~rdy)) begin
      e.wb = '0;
    end else if (acc & ~al) begin
      e.wb   = '0;
      e.mask = 38'h20_0000_0000;
    end else begin
      e.wb = {rw, rd, d};
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    chk("memwb", 64'(memWb & e.mask), 64'(e.wb & e.mask));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [105:0] alu5, ldA, stB, ldMis, jal, ldC, ldD;
    alu5  = mk(32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 32'h5, 32'h0);
    ldA   = mk(32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0);
    stB   = mk(32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h1234);
    ldMis = mk(32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd7, 32'h102, 32'h0);
    jal   = mk(32'h0040_0008, 2'b10, 1'b1, 1'b0, 1'b0, 5'd31,
               32'h0000_1234, 32'h0);
    ldC   = mk(32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'h0);
    ldD   = mk(32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd10, 32'h304, 32'hAA);

    rst = 1'b1;
    exMem = '0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    #12;
    chk("rst_memwb", 64'(memWb), 64'h0);
    chk("rst_fault", 64'(memFault), 64'h0);
    chk("rst_req", 64'(bus.dmem_req), 64'h0);
    chk("rst_stall", 64'(memStall), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cyc(alu5, 1'b0, 32'h0, 1'b0);
    cyc(ldA, 1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) cyc(stB, 1'b0, 32'h0, 1'b1);
    cyc(stB, 1'b1, 32'h0, 1'b0);
    cyc(ldMis, 1'b1, 32'h5555_5555, 1'b0);
    cyc(alu5, 1'b0, 32'h0, 1'b0);
    cyc(jal, 1'b0, 32'h0, 1'b0);
    cyc(ldC, 1'b0, 32'hBAD0_BAD0, 1'b1);
    cyc(ldC, 1'b1, 32'hCAFE_F00D, 1'b0);
    cyc(ldD, 1'b0, 32'h0, 1'b1);
    cyc(ldD, 1'b1, 32'h0, 1'b0);
    cyc(ldA, 1'b1, 32'h0BAD_CAFE, 1'b0);

    cyc(alu5, 1'b0, 32'h0, 1'b0);
    cyc(stB, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    chk("midrst_memwb", 64'(memWb), 64'h0);
    @(posedge clk);
    #1;
    chk("midrst_hold", 64'(memWb), 64'h0);
    exMem = '0;
    #1;
    chk("midrst_req", 64'(bus.dmem_req), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(alu5, 1'b0, 32'h0, 1'b0);
    cyc(ldA, 1'b1, 32'h1357_9BDF, 1'b0);

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) cyc(ldC, 1'b0, 32'h0, 1'b1);
    chk("fault_pre", 64'(memFault), 64'h0);
    cyc(ldC, 1'b0, 32'h0, 1'b0);
    chk("fault_set", 64'(memFault), 64'h1);
    cyc(alu5, 1'b0, 32'h0, 1'b0);
    chk("fault_sticky", 64'(memFault), 64'h1);
    cyc(ldA, 1'b1, 32'h2468_ACE0, 1'b0);
`else
    for (int i = 0; i < 8; i++) cyc(ldC, 1'b0, 32'h0, 1'b1);
    cyc(ldC, 1'b1, 32'h7777_0001, 1'b0);
    chk("fault_off", 64'(memFault), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
